sparse_weight_encoder_2of4: RTL

//  Transmit side of the 2:4 structured-sparse weight interface consumed by the sparse dot-product PEs.

---
 rtl/sparse_weight_encoder_2of4_pkg.sv | 18 +
 rtl/sparse_weight_encoder_2of4_top2_select.sv | 49 ++++
 rtl/sparse_weight_encoder_2of4.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sparse_weight_encoder_2of4_pkg.sv
// Shared definitions for the 2:4 structured-sparse weight interface.
// Used by the encoder on the transmit side and by the PE weight loaders.
package sparse_pkg;

    localparam int SP_N   = 4;
    localparam int SP_NNZ = 2;
    localparam int SP_BW  = 4;

    typedef logic [1:0]      sp_idx_t;
    typedef logic [SP_N-1:0] sp_mask_t;

    typedef struct packed {
        logic [SP_NNZ-1:0][SP_BW-1:0] weights;
        sp_mask_t                     mask;
        logic                         last;
    } sp_group_t;

endpackage

// File: rtl/sparse_weight_encoder_2of4_top2_select.sv
// Combinational 2-of-4 magnitude selector.
// Keeps the two largest values (ties go to the lower position), reports the
// position mask, the kept values in ascending position order, and whether
// any dropped value was nonzero.
module sparse_top2_select
    import sparse_pkg::*;
#(
    parameter int BW = SP_BW
) (
    input  logic [SP_N-1:0][BW-1:0]   values,
    output sp_mask_t                  mask,
    output logic [SP_NNZ-1:0][BW-1:0] kept,
    output logic                      pruned
);

    logic [2:0] beats;
    sp_idx_t    slot;

    // Rank each position by how many others beat it, then pack survivors in position order
    always_comb begin
        mask   = '0;
        kept   = '0;
        pruned = 1'b0;
        beats  = '0;
        slot   = '0;
        for (int i = 0; i < SP_N; i++) begin
            beats = '0;
            for (int j = 0; j < SP_N; j++) begin
                if (j != i && ((values[j] > values[i]) || ((values[j] == values[i]) && (j < i)))) begin
                    beats = beats + 3'd1;
                end
            end
            if (beats < 3'(SP_NNZ)) begin
                mask[i] = 1'b1;
            end else if (values[i] != '0) begin
                pruned = 1'b1;
            end
        end
        for (int i = 0; i < SP_N; i++) begin
            if (mask[i]) begin
                if (slot < sp_idx_t'(SP_NNZ)) begin
                    kept[slot[0]] = values[i];
                end
                slot = slot + sp_idx_t'(1);
            end
        end
    end

endmodule

// File: rtl/sparse_weight_encoder_2of4.sv
// Transmit side of the 2:4 structured-sparse weight interface.
// Dense groups are registered in stage 1, reduced to their two largest values
// and pushed into a small output FIFO presented with valid/ready.
// Optional statistics counters are built when SPARSE_ENC_STATS_EN is defined.
module sparse_weight_encoder_2of4
    import sparse_pkg::*;
#(
    parameter int BW         = SP_BW,
    parameter int N          = SP_N,
    parameter int NNZ        = SP_NNZ,
    parameter int FIFO_DEPTH = 2
`ifdef SPARSE_ENC_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                   gated_clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0][BW-1:0]   in_weights,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NNZ-1:0][BW-1:0] out_weights,
    output logic [N-1:0]           out_w_index,
    output logic                   out_last
`ifdef SPARSE_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0]       pruned_cnt,
    output logic [CNT_W-1:0]       group_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    logic                   s1_valid;
    logic [N-1:0][BW-1:0]   s1_weights;
    logic                   s1_last;

    sp_mask_t               sel_mask;
    logic [NNZ-1:0][BW-1:0] sel_kept;

    logic [NNZ-1:0][BW-1:0] fifo_weights [FIFO_DEPTH];
    sp_mask_t               fifo_mask    [FIFO_DEPTH];
    logic                   fifo_last    [FIFO_DEPTH];
    ptr_t                   wr_ptr;
    ptr_t                   rd_ptr;
    cnt_t                   count;

    logic                   push;
    logic                   pop;
    logic                   accept;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && ((count != cnt_t'(FIFO_DEPTH)) || pop);
    assign in_ready  = !reset && (!s1_valid || push);
    assign accept    = in_valid && in_ready;

`ifdef SPARSE_ENC_STATS_EN
    logic sel_pruned;
    logic fifo_pruned [FIFO_DEPTH];

    sparse_top2_select #(.BW(BW)) u_select (
        .values (s1_weights),
        .mask   (sel_mask),
        .kept   (sel_kept),
        .pruned (sel_pruned)
    );
`else
    sparse_top2_select #(.BW(BW)) u_select (
        .values (s1_weights),
        .mask   (sel_mask),
        .kept   (sel_kept),
        .pruned ()
    );
`endif

    // Stage-1 occupancy: filled on accept, emptied once its group moves into the FIFO
    always_ff @(posedge gated_clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage-1 payload capture; contents are meaningless while s1_valid is low
    always_ff @(posedge gated_clk) begin
        if (accept) begin
            s1_weights <= in_weights;
            s1_last    <= in_last;
        end
    end

    // FIFO storage write of the selected group
    always_ff @(posedge gated_clk) begin
        if (push) begin
            fifo_weights[wr_ptr] <= sel_kept;
            fifo_mask[wr_ptr]    <= sel_mask;
            fifo_last[wr_ptr]    <= s1_last;
`ifdef SPARSE_ENC_STATS_EN
            fifo_pruned[wr_ptr]  <= sel_pruned;
`endif
        end
    end

    // FIFO pointers wrap naturally since depth is a power of two; count tracks occupancy
    always_ff @(posedge gated_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // Present the FIFO head, forcing zeros whenever nothing is valid
    always_comb begin
        out_weights = '0;
        out_w_index = '0;
        out_last    = 1'b0;
        if (out_valid) begin
            out_weights = fifo_weights[rd_ptr];
            out_w_index = fifo_mask[rd_ptr];
            out_last    = fifo_last[rd_ptr];
        end
    end

`ifdef SPARSE_ENC_STATS_EN
    // Saturating statistics counted on each output transfer
    always_ff @(posedge gated_clk) begin
        if (reset) begin
            group_cnt  <= '0;
            pruned_cnt <= '0;
        end else if (pop) begin
            if (group_cnt != '1) begin
                group_cnt <= group_cnt + CNT_W'(1);
            end
            if (fifo_pruned[rd_ptr] && (pruned_cnt != '1)) begin
                pruned_cnt <= pruned_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
